sram_dp_bytewise: RTL and testbench
===================================

# sram_dp_bytewise

Parametrised true-dual-port synchronous SRAM with per-port byte-enable writes, selectable read latency and write-mode, cross-port collision resolution, and an optional post-reset clear engine. It is the next generation of the team's single-port byte-write SRAM and is used wherever two masters share a buffer (DMA plus core, producer plus consumer). Each port has its own read-valid strobe, so consumers never have to count latency themselves.

## Interface
- DATA_WIDTH, 32: word width in bits; multiple of 8; NB = DATA_WIDTH/8 byte lanes.
- ADDR_WIDTH, 10: address width; DEPTH = 2**ADDR_WIDTH words.
- READ_LATENCY, 1: 1 or 2 clock edges from accepted access to data; other values are illegal (elaboration error).
- WRITE_MODE, 0: 0 = read-first, 1 = write-first, 2 = no-change; applies to same-port access.
- CLEAR_ON_RESET, 1: 1 = zero all words after reset; 0 = contents untouched by reset.
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ready  out  1  high when ports accept accesses; low during clear.
- a_en / b_en  in  1  port access enable.
- a_we / b_we  in  NB  byte write enables; bit i covers din[8i+7:8i].
- a_addr / b_addr  in  ADDR_WIDTH  word address.
- a_din / b_din  in  DATA_WIDTH  write data.
- a_dout / b_dout  out  DATA_WIDTH  read data; holds last value between reads.
- a_rvalid / b_rvalid  out  1  one-cycle strobe marking valid dout.

## Operation
- Accepted access: x_en=1 and ready=1 at a rising edge. If ready=0, x_en is ignored: no write, no rvalid.
- Write: bytes with x_we[i]=1 are updated; the other bytes are preserved.
- Same-port read data per WRITE_MODE:
  - Read-first: dout = the word before the write.
  - Write-first: dout = the merged word (new enabled bytes, old others).
  - No-change: a write (|x_we=1) produces no rvalid and leaves dout unchanged.
- Pure reads (x_we=0) always produce rvalid.
- Cross-port, same address, same edge:
  - Both write: per byte, port A wins where a_we[i]=1; otherwise port B's byte is written if b_we[i]=1.
  - One writes, the other reads: the reader always gets the old word, regardless of WRITE_MODE.
  - Both read: both get the same word.
- Clear FSM states: CLEAR, READY.
  - rst=1 forces CLEAR (if CLEAR_ON_RESET=1) or READY (if 0), and resets the clear counter to 0.
  - In CLEAR, each edge with rst=0 writes zero to word[counter] and increments the counter.
  - After writing word DEPTH-1, the FSM goes to READY. READY is terminal until the next rst.
- Reset mid-clear restarts the sweep from address 0.
- Reset values: ready=0 (CLEAR_ON_RESET=1) or 1 (0); a_dout=b_dout=0; a_rvalid=b_rvalid=0; all pipeline stages are cleared. The memory array has no reset apart from the clear sweep.

## Timing
- Latency 1: an access accepted at edge N gives dout/rvalid valid after edge N+1.
- Latency 2: an access accepted at edge N gives dout/rvalid valid after edge N+2. The second stage is a plain register.
- Full throughput: one access per port per cycle; back-to-back reads yield back-to-back rvalid.
- A write at edge N is visible to any read accepted at edge N+1 or later, on either port.
- Clear: rst is high at edge 0 and low from edge 1 onward. Words 0..DEPTH-1 are written at edges 1..DEPTH, and ready=1 after edge DEPTH. An access is first accepted at edge DEPTH+1.
- rvalid is never asserted for an access issued while ready=0, even if ready rises before that access's latency would have elapsed.

## Test plan
- Clear sweep (ADDR_WIDTH=4, CLEAR_ON_RESET=1): pulse rst for 1 cycle -> ready=0 for exactly 16 edges, then ready=1; reads of all 16 words return 0x00000000; a_en pulsed during clear yields no rvalid.
- Byte write, read-first, latency 1: write 0xAABBCCDD to addr 5 with we=4'b1111, then we=4'b0101 with din 0x11223344, reading on the same port -> the second access returns 0xAABBCCDD; a following read returns 0xAA22CC44, with rvalid exactly one cycle after each access.
- Write-first and no-change, same stimulus: write-first returns 0xAA22CC44 on the second access. No-change gives no rvalid on either write and dout keeps its previous value.
- Dual-write collision: a_we=4'b0011, a_din=0x000000FF; b_we=4'b1110, b_din=0x12345600; addr 7, on a word already holding 0 -> readback 0x123400FF.
- Cross-port read/write, latency 2: word 3 holds 0x0; A writes 0xDEADBEEF while B reads addr 3 -> b_dout=0x0 with b_rvalid two edges later; B reads again next cycle -> 0xDEADBEEF.
- Reset mid-clear (ADDR_WIDTH=4): assert rst at edge 8 of the sweep -> sweep restarts; ready rises exactly 16 edges after rst deasserts; a_dout and b_dout read 0 and rvalid is low during reset.

Source files
------------

// File: rtl/sram_dp_bytewise.sv
// True dual-port byte-write SRAM with 1- or 2-cycle read latency, same-port
// write mode selection and an optional zeroing sweep after reset.
module sram_dp_bytewise #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int READ_LATENCY   = 1,
  parameter int WRITE_MODE     = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    ready,
  input  logic                    a_en,
  input  logic [DATA_WIDTH/8-1:0] a_we,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [DATA_WIDTH-1:0]   a_din,
  output logic [DATA_WIDTH-1:0]   a_dout,
  output logic                    a_rvalid,
  input  logic                    b_en,
  input  logic [DATA_WIDTH/8-1:0] b_we,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  input  logic [DATA_WIDTH-1:0]   b_din,
  output logic [DATA_WIDTH-1:0]   b_dout,
  output logic                    b_rvalid
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("sram_dp_bytewise: READ_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("sram_dp_bytewise: DATA_WIDTH must be a multiple of 8");
  end
  if (WRITE_MODE < 0 || WRITE_MODE > 2) begin : g_bad_mode
    $error("sram_dp_bytewise: WRITE_MODE must be 0, 1 or 2");
  end

  // state | meaning
  // CLEAR | zero sweep in progress, port accesses ignored
  // READY | ports accept accesses; held until the next rst
  typedef enum logic {CLEAR, READY} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  clr_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      clr_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_addr == ADDR_WIDTH'(DEPTH - 1)) state_nxt = READY;
      READY:   state_nxt = READY;
      default: state_nxt = CLEAR;
    endcase
  end

  assign ready  = (state == READY);
  assign clr_we = (state == CLEAR) && !rst;

  logic                  acc_p  [2];
  logic [NB-1:0]         we_p   [2];
  logic [ADDR_WIDTH-1:0] addr_p [2];
  logic [DATA_WIDTH-1:0] din_p  [2];
  logic [DATA_WIDTH-1:0] mem    [DEPTH];

  assign acc_p[0]  = a_en && ready;
  assign acc_p[1]  = b_en && ready;
  assign we_p[0]   = a_we;
  assign we_p[1]   = b_we;
  assign addr_p[0] = a_addr;
  assign addr_p[1] = b_addr;
  assign din_p[0]  = a_din;
  assign din_p[1]  = b_din;

  // Port A is written after port B so it wins overlapping bytes on a collision.
  always_ff @(posedge clk) begin
    if (clr_we) mem[clr_addr] <= '0;
    for (int i = 0; i < NB; i++) begin
      if (acc_p[1] && we_p[1][i]) mem[addr_p[1]][8*i +: 8] <= din_p[1][8*i +: 8];
      if (acc_p[0] && we_p[0][i]) mem[addr_p[0]][8*i +: 8] <= din_p[0][8*i +: 8];
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic                  rd_v, v0, rv_q;
    logic [DATA_WIDTH-1:0] old_word, merged, rd_d, d0, dout_q;

    assign old_word = mem[addr_p[p]];

    always_comb begin
      merged = old_word;
      for (int i = 0; i < NB; i++) begin
        if (we_p[p][i]) merged[8*i +: 8] = din_p[p][8*i +: 8];
      end
    end

    assign rd_v = acc_p[p] && !(WRITE_MODE == 2 && (|we_p[p]));
    assign rd_d = (WRITE_MODE == 1) ? merged : old_word;

    // The array word is captured on the accepting edge so reads see pre-write data.
    always_ff @(posedge clk) begin
      if (rst) begin
        v0 <= 1'b0;
        d0 <= '0;
      end else begin
        v0 <= rd_v;
        d0 <= rd_d;
      end
    end

    if (READ_LATENCY == 2) begin : g_lat2
      logic                  v1;
      logic [DATA_WIDTH-1:0] d1;
      always_ff @(posedge clk) begin
        if (rst) begin
          v1     <= 1'b0;
          d1     <= '0;
          rv_q   <= 1'b0;
          dout_q <= '0;
        end else begin
          v1   <= v0;
          d1   <= d0;
          rv_q <= v1;
          if (v1) dout_q <= d1;
        end
      end
    end else begin : g_lat1
      always_ff @(posedge clk) begin
        if (rst) begin
          rv_q   <= 1'b0;
          dout_q <= '0;
        end else begin
          rv_q <= v0;
          if (v0) dout_q <= d0;
        end
      end
    end
  end

  assign a_dout   = g_port[0].dout_q;
  assign a_rvalid = g_port[0].rv_q;
  assign b_dout   = g_port[1].dout_q;
  assign b_rvalid = g_port[1].rv_q;

endmodule

// File: tb/tb_sram_dp_bytewise.sv
// Randomized and directed bench for sram_dp_bytewise: three cleared instances
// (read-first/L1, write-first/L2, no-change/L1) plus one uncleared instance.
module tb_sram_dp_bytewise;
  localparam int AW = 4;
  localparam int NW = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_en, b_en;
  logic [3:0]  a_we, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [31:0] a_din, b_din;

  logic        rdy_w  [3];
  logic        rv_w   [3][2];
  logic [31:0] dout_w [3][2];
  logic        rdy3, a_rv3, b_rv3;
  logic [31:0] a_do3, b_do3;

  always #5 clk = ~clk;

  sram_dp_bytewise #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .READ_LATENCY(1), .WRITE_MODE(0), .CLEAR_ON_RESET(1)) u_rf (
    .clk(clk), .rst(rst), .ready(rdy_w[0]),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(dout_w[0][0]), .a_rvalid(rv_w[0][0]),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(dout_w[0][1]), .b_rvalid(rv_w[0][1]));

  sram_dp_bytewise #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .READ_LATENCY(2), .WRITE_MODE(1), .CLEAR_ON_RESET(1)) u_wf (
    .clk(clk), .rst(rst), .ready(rdy_w[1]),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(dout_w[1][0]), .a_rvalid(rv_w[1][0]),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(dout_w[1][1]), .b_rvalid(rv_w[1][1]));

  sram_dp_bytewise #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .READ_LATENCY(1), .WRITE_MODE(2), .CLEAR_ON_RESET(1)) u_nc (
    .clk(clk), .rst(rst), .ready(rdy_w[2]),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(dout_w[2][0]), .a_rvalid(rv_w[2][0]),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(dout_w[2][1]), .b_rvalid(rv_w[2][1]));

  sram_dp_bytewise #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .READ_LATENCY(2), .WRITE_MODE(0), .CLEAR_ON_RESET(0)) u_nclr (
    .clk(clk), .rst(rst), .ready(rdy3),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_do3), .a_rvalid(a_rv3),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_do3), .b_rvalid(b_rv3));

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: word array, clear progress and a per-instance delay line.
  logic [31:0] mem_m [NW];
  bit          m_ready;
  int          m_ptr;
  bit          rst_at_edge;
  bit          e_rv   [3][2];
  logic [31:0] e_dout [3][2];
  bit          dl_v   [3][2][2];
  logic [31:0] dl_d   [3][2][2];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din, input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = din[8*b +: 8];
    return r;
  endfunction

  task automatic model_edge();
    bit          en [2];
    logic [3:0]  we [2];
    logic [AW-1:0] ad [2];
    logic [31:0] dn [2];
    logic [31:0] old [2];
    bit          acc_ok, nv;
    logic [31:0] nd;
    int          lat;
    en[0] = a_en;   en[1] = b_en;
    we[0] = a_we;   we[1] = b_we;
    ad[0] = a_addr; ad[1] = b_addr;
    dn[0] = a_din;  dn[1] = b_din;
    rst_at_edge = rst;
    if (rst) begin
      m_ready = 1'b0;
      m_ptr   = 0;
      for (int i = 0; i < 3; i++)
        for (int p = 0; p < 2; p++) begin
          e_rv[i][p] = 1'b0; e_dout[i][p] = '0;
          dl_v[i][p][0] = 1'b0; dl_v[i][p][1] = 1'b0;
          dl_d[i][p][0] = '0;   dl_d[i][p][1] = '0;
        end
    end else begin
      acc_ok = m_ready;
      old[0] = mem_m[ad[0]];
      old[1] = mem_m[ad[1]];
      if (m_ready) begin
        if (en[1]) mem_m[ad[1]] = merge(mem_m[ad[1]], dn[1], we[1]);
        if (en[0]) mem_m[ad[0]] = merge(mem_m[ad[0]], dn[0], we[0]);
      end else begin
        mem_m[m_ptr] = '0;
        m_ptr++;
        if (m_ptr == NW) m_ready = 1'b1;
      end
      for (int i = 0; i < 3; i++)
        for (int p = 0; p < 2; p++) begin
          nv  = acc_ok && en[p] && !(i == 2 && we[p] != 4'h0);
          nd  = (i == 1) ? merge(old[p], dn[p], we[p]) : old[p];
          lat = (i == 1) ? 2 : 1;
          e_rv[i][p] = dl_v[i][p][lat-1];
          if (dl_v[i][p][lat-1]) e_dout[i][p] = dl_d[i][p][lat-1];
          dl_v[i][p][1] = dl_v[i][p][0];
          dl_d[i][p][1] = dl_d[i][p][0];
          dl_v[i][p][0] = nv;
          dl_d[i][p][0] = nd;
        end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("ready%0d", i), 32'(rdy_w[i]), 32'(m_ready));
      for (int p = 0; p < 2; p++) begin
        check_val($sformatf("rvalid%0d_%0d", i, p), 32'(rv_w[i][p]), 32'(e_rv[i][p]));
        check_val($sformatf("dout%0d_%0d", i, p), dout_w[i][p], e_dout[i][p]);
      end
    end
    check_val("ready_noclear", 32'(rdy3), 32'd1);
    if (rst_at_edge) begin
      check_val("rst_a_rvalid_noclear", 32'(a_rv3), 32'd0);
      check_val("rst_b_rvalid_noclear", 32'(b_rv3), 32'd0);
      check_val("rst_a_dout_noclear", a_do3, 32'd0);
      check_val("rst_b_dout_noclear", b_do3, 32'd0);
    end
  endtask

  task automatic idle();
    a_en = 1'b0; a_we = '0; a_addr = '0; a_din = '0;
    b_en = 1'b0; b_we = '0; b_addr = '0; b_din = '0;
  endtask

  task automatic acc_a(input logic [3:0] we, input int addr, input logic [31:0] din);
    a_en = 1'b1; a_we = we; a_addr = AW'(addr); a_din = din;
  endtask

  task automatic acc_b(input logic [3:0] we, input int addr, input logic [31:0] din);
    b_en = 1'b1; b_we = we; b_addr = AW'(addr); b_din = din;
  endtask

  task automatic rand_inputs();
    a_en   = ($urandom_range(0, 3) != 0);
    a_we   = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
    a_addr = AW'($urandom_range(0, NW - 1));
    a_din  = $urandom;
    b_en   = ($urandom_range(0, 3) != 0);
    b_we   = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
    b_addr = ($urandom_range(0, 2) == 0) ? a_addr : AW'($urandom_range(0, NW - 1));
    b_din  = $urandom;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (NW) begin
      rand_inputs();
      tick();
    end
    idle();
    tick();
    for (int k = 0; k < NW; k++) begin
      acc_a(4'h0, k, 32'h0);
      acc_b(4'h0, NW - 1 - k, 32'h0);
      tick();
    end
    idle();
    tick();

    acc_a(4'hF, 5, 32'hAABBCCDD); tick();
    acc_a(4'h5, 5, 32'h11223344); tick();
    acc_a(4'h0, 5, 32'h0);        tick();
    check_val("rf_second_access", dout_w[0][0], 32'hAABBCCDD);
    idle();                       tick();
    check_val("rf_readback", dout_w[0][0], 32'hAA22CC44);
    check_val("wf_second_access", dout_w[1][0], 32'hAA22CC44);
    tick();
    tick();

    acc_b(4'hF, 6, 32'h01020304); tick();
    acc_b(4'hA, 6, 32'hF0E0D0C0); tick();
    acc_b(4'h0, 6, 32'h0);        tick();
    idle(); tick(); tick(); tick();

    acc_a(4'h3, 7, 32'h000000FF);
    acc_b(4'hE, 7, 32'h12345600); tick();
    idle();
    acc_a(4'h0, 7, 32'h0);        tick();
    idle();                       tick();
    check_val("collision_readback", dout_w[0][0], 32'h123400FF);
    tick();

    acc_a(4'hF, 3, 32'hDEADBEEF);
    acc_b(4'h0, 3, 32'h0);        tick();
    idle();
    acc_b(4'h0, 3, 32'h0);        tick();
    idle();                       tick();
    check_val("xport_old_rvalid", 32'(rv_w[1][1]), 32'd1);
    check_val("xport_old_data", dout_w[1][1], 32'h0);
    tick();
    check_val("xport_new_data", dout_w[1][1], 32'hDEADBEEF);
    tick();

    repeat (300) begin
      rand_inputs();
      tick();
    end

    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (7) begin
      rand_inputs();
      tick();
    end
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (NW) begin
      rand_inputs();
      tick();
    end
    repeat (200) begin
      rand_inputs();
      tick();
    end
    idle();
    tick();
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
